mem_block_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 38 +++
 rtl/mem_block_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the block-transfer arbiter: FSM states, arbitration modes and op codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StRelease
  } arbState_e;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Channel index width; a single-channel build still carries a 1-bit id.
  function automatic int unsigned idWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: round-robin starting after lastGrant, or lowest index first.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned IdW      = idWidth(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IdW-1:0]    lastGrant,
  output logic [IdW-1:0]    pick,
  output logic              found
);

  always_comb begin
    pick  = '0;
    found = 1'b0;
    if (ARB_MODE == ARB_FIXED) begin
      // Descending scan so the lowest requesting index is written last.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i]) begin
          pick  = IdW'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
        int unsigned idx;
        idx = (32'(lastGrant) + k) % NUM_CH;
        if (!found && req[idx]) begin
          pick  = IdW'(idx);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_block_arbiter.sv
// Shares one main-memory block port among NUM_CH cache clients; captures the granted request,
// holds it on the memory side until the matching valid, then pulses done for one cycle.
module mem_block_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned BLK_W    = 256,
  parameter int unsigned ARB_MODE = 0,
  localparam int unsigned IdW     = idWidth(NUM_CH)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_CH-1:0]         ch_rd_req,
  input  logic [NUM_CH-1:0]         ch_wr_req,
  input  logic [NUM_CH*ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH*BLK_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]         ch_done,
  output logic [BLK_W-1:0]          ch_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_blk_read,
  output logic                      mem_blk_write,
  output logic [BLK_W-1:0]          mem_wdata,
  input  logic [BLK_W-1:0]          mem_rdata,
  input  logic                      mem_read_valid,
  input  logic                      mem_write_valid,
  output logic                      grant_valid,
  output logic [IdW-1:0]            grant_id
);

  arbState_e         stateQ, stateD;
  logic              opQ;
  logic [ADDR_W-1:0] addrQ;
  logic [BLK_W-1:0]  wdataQ, rdataQ;
  logic [IdW-1:0]    gntQ, lastGrantQ;

  logic [NUM_CH-1:0] req;
  logic [IdW-1:0]    pick;
  logic              found;
  logic              xferDone;
  logic [ADDR_W-1:0] selAddr;
  logic [BLK_W-1:0]  selWdata;
  logic              selWr;

  assign req = ch_rd_req | ch_wr_req;

  rr_pick #(
    .NUM_CH  (NUM_CH),
    .ARB_MODE(ARB_MODE),
    .IdW     (IdW)
  ) uPick (
    .req      (req),
    .lastGrant(lastGrantQ),
    .pick     (pick),
    .found    (found)
  );

  always_comb begin
    selAddr  = '0;
    selWdata = '0;
    selWr    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pick == IdW'(i)) begin
        selAddr  = ch_addr[i*ADDR_W +: ADDR_W];
        selWdata = ch_wdata[i*BLK_W +: BLK_W];
        selWr    = ch_wr_req[i];
      end
    end
  end

  // Only the valid matching the captured op ends the transfer.
  assign xferDone = (stateQ == StBusy) && ((opQ == OP_WR) ? mem_write_valid : mem_read_valid);

  always_ff @(posedge CLK) begin
    if (RESET) stateQ <= StIdle;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:    if (found) stateD = StBusy;
      StBusy:    if (xferDone) stateD = StRelease;
      StRelease: stateD = StIdle;
      default:   stateD = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      opQ        <= OP_RD;
      addrQ      <= '0;
      wdataQ     <= '0;
      rdataQ     <= '0;
      gntQ       <= '0;
      lastGrantQ <= IdW'(NUM_CH - 1);
    end else begin
      if (stateQ == StIdle && found) begin
        gntQ       <= pick;
        lastGrantQ <= pick;
        opQ        <= selWr ? OP_WR : OP_RD;
        addrQ      <= selAddr;
        wdataQ     <= selWdata;
      end
      if (xferDone && opQ == OP_RD) rdataQ <= mem_rdata;
    end
  end

  always_comb begin
    grant_valid   = (stateQ == StBusy);
    mem_blk_read  = (stateQ == StBusy) && (opQ == OP_RD);
    mem_blk_write = (stateQ == StBusy) && (opQ == OP_WR);
    mem_addr      = addrQ;
    mem_wdata     = wdataQ;
    ch_rdata      = rdataQ;
    grant_id      = gntQ;
    ch_done       = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (stateQ == StRelease && gntQ == IdW'(i)) ch_done[i] = 1'b1;
    end
  end

endmodule
